// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point add/subtract engine.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ADD    = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    OUT    = 3'd5
  } fp_add_state_e;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } fp_rnd_e;

  // Bit positions inside the 4-bit exception vector.
  localparam int EXC_INV = 3;
  localparam int EXC_OVF = 2;
  localparam int EXC_UNF = 1;
  localparam int EXC_NX  = 0;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0]           value_i,
  output logic [$clog2(WIDTH+1)-1:0] count_o
);

  localparam int CW = $clog2(WIDTH + 1);

  // Scanning upward lets the highest set bit overwrite every lower one.
  always_comb begin
    count_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value_i[i]) count_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_engine.sv
// Multi-cycle IEEE-754 add/subtract engine with four rounding modes,
// subnormal support and valid/ready handshakes on both sides.
module fp_addsub_engine
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [EXP_W+MAN_W:0]   Datain1,
  input  logic [EXP_W+MAN_W:0]   Datain2,
  input  logic                   Op,
  input  logic [1:0]             Rnd_mode,
  input  logic                   Data_valid,
  output logic                   Data_ready,
  output logic [EXP_W+MAN_W:0]   Dataout,
  output logic [3:0]             Exc,
  output logic                   Dataout_valid,
  input  logic                   Dataout_ready,
  output logic [2:0]             Debug
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int XW  = MAN_W + 4;   // {hidden, fraction, G, R, S}
  localparam int SW  = MAN_W + 5;   // XW plus carry
  localparam int EW  = EXP_W + 1;   // headroom for exponent overflow
  localparam int LZW = $clog2(XW + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  fp_add_state_e   state_q, state_d;
  fp_rnd_e         rnd_q, rnd_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic            sign_q, sign_d, eop_q, eop_d, zsame_q, zsame_d, valid_q, valid_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic [XW-1:0]   m1_q, m1_d, m2_q, m2_d, nm_q, nm_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [3:0]      exc_q, exc_d;

  logic              sa, sb, s1, s2, swap, aInf, bInf, aNan, bNan, aZero, bZero, nanCase;
  logic [EXP_W-1:0]  ea, eb, eaEff, ebEff, e1, e2, diff;
  logic [MAN_W-1:0]  fa, fb;
  logic [MAN_W:0]    ma, mb, m1u, m2u;
  logic [XW-1:0]     m2x, shifted, aligned;
  logic              bigShift, lost;

  assign sa    = a_q[W-1];
  assign sb    = b_q[W-1];
  assign ea    = a_q[W-2:MAN_W];
  assign eb    = b_q[W-2:MAN_W];
  assign fa    = a_q[MAN_W-1:0];
  assign fb    = b_q[MAN_W-1:0];
  assign aInf  = (&ea) && (fa == '0);
  assign bInf  = (&eb) && (fb == '0);
  assign aNan  = (&ea) && (fa != '0);
  assign bNan  = (&eb) && (fb != '0);
  assign aZero = (ea == '0) && (fa == '0);
  assign bZero = (eb == '0) && (fb == '0);
  assign nanCase = aNan || bNan || (aInf && bInf && (sa != sb));

  // Subnormals use effective exponent 1 with a zero hidden bit.
  assign eaEff = (ea == '0) ? EXP_W'(1) : ea;
  assign ebEff = (eb == '0) ? EXP_W'(1) : eb;
  assign ma    = {(ea != '0), fa};
  assign mb    = {(eb != '0), fb};
  assign swap  = {ebEff, mb} > {eaEff, ma};
  assign s1    = swap ? sb : sa;
  assign s2    = swap ? sa : sb;
  assign e1    = swap ? ebEff : eaEff;
  assign e2    = swap ? eaEff : ebEff;
  assign m1u   = swap ? mb : ma;
  assign m2u   = swap ? ma : mb;
  assign diff  = e1 - e2;

  assign m2x      = {m2u, 3'b000};
  assign bigShift = 32'(diff) >= 32'(MAN_W + 3);
  assign shifted  = m2x >> diff;
  assign lost     = |(m2x & ~({XW{1'b1}} << diff));
  assign aligned  = bigShift ? {{(XW-1){1'b0}}, |m2u} : {shifted[XW-1:1], shifted[0] | lost};

  logic            carry;
  logic [XW-1:0]   lowSum, normShifted;
  logic [LZW-1:0]  lzCount;
  logic [31:0]     lz32, limit32, shAmt;

  assign carry  = sum_q[SW-1];
  assign lowSum = sum_q[XW-1:0];

  fp_lzc #(.WIDTH(XW)) u_lzc (
    .value_i (lowSum),
    .count_o (lzCount)
  );

  // Left shift stops once the exponent reaches 1, leaving a subnormal.
  assign lz32        = 32'(lzCount);
  assign limit32     = 32'(exp_q) - 32'd1;
  assign shAmt       = (lz32 > limit32) ? limit32 : lz32;
  assign normShifted = lowSum << shAmt;

  logic              g, r, s, lsb, nx, roundInc, rcarry, ovf, ovfToMax;
  logic [MAN_W+1:0]  rsum;
  logic [MAN_W:0]    rman;
  logic [EW-1:0]     rexp;
  logic [EXP_W-1:0]  packExp;

  assign g        = nm_q[2];
  assign r        = nm_q[1];
  assign s        = nm_q[0];
  assign lsb      = nm_q[3];
  assign nx       = g | r | s;
  assign roundInc = (rnd_q == RNE) ? (g & (r | s | lsb)) :
                    (rnd_q == RUP) ? (nx & ~sign_q) :
                    (rnd_q == RDN) ? (nx & sign_q) : 1'b0;
  assign rsum     = {1'b0, nm_q[XW-1:3]} + (MAN_W+2)'(roundInc);
  assign rcarry   = rsum[MAN_W+1];
  assign rman     = rcarry ? rsum[MAN_W+1:1] : rsum[MAN_W:0];
  assign rexp     = exp_q + EW'(rcarry);
  assign ovf      = rexp >= {1'b0, {EXP_W{1'b1}}};
  assign ovfToMax = (rnd_q == RTZ) || ((rnd_q == RUP) && sign_q) || ((rnd_q == RDN) && !sign_q);
  assign packExp  = rman[MAN_W] ? rexp[EXP_W-1:0] : '0;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rnd_d   = rnd_q;
    sign_d  = sign_q;
    eop_d   = eop_q;
    zsame_d = zsame_q;
    exp_d   = exp_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    sum_d   = sum_q;
    nm_d    = nm_q;
    res_d   = res_q;
    exc_d   = exc_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (Data_valid) begin
          a_d     = Datain1;
          b_d     = Datain2 ^ {Op, {(W-1){1'b0}}};
          rnd_d   = fp_rnd_e'(Rnd_mode);
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        if (nanCase) begin
          res_d          = QNAN;
          exc_d          = '0;
          exc_d[EXC_INV] = 1'b1;
          state_d        = OUT;
        end else if (aInf || bInf) begin
          res_d   = aInf ? a_q : b_q;
          exc_d   = '0;
          state_d = OUT;
        end else begin
          sign_d  = s1;
          eop_d   = s1 ^ s2;
          zsame_d = aZero && bZero && (sa == sb);
          exp_d   = {1'b0, e1};
          m1_d    = {m1u, 3'b000};
          m2_d    = aligned;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d   = eop_q ? ({1'b0, m1_q} - {1'b0, m2_q}) : ({1'b0, m1_q} + {1'b0, m2_q});
        state_d = NORM;
      end
      NORM: begin
        if (carry) begin
          nm_d  = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
          exp_d = exp_q + EW'(1);
        end else begin
          nm_d  = normShifted;
          exp_d = exp_q - EW'(shAmt);
        end
        state_d = ROUND;
      end
      ROUND: begin
        exc_d   = '0;
        state_d = OUT;
        if (nm_q == '0) begin
          res_d = zsame_q ? {sign_q, {(W-1){1'b0}}} : {(rnd_q == RDN), {(W-1){1'b0}}};
        end else if (ovf) begin
          res_d = ovfToMax ? {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                           : {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          exc_d[EXC_OVF] = 1'b1;
          exc_d[EXC_NX]  = 1'b1;
        end else begin
          res_d          = {sign_q, packExp, rman[MAN_W-1:0]};
          exc_d[EXC_UNF] = !nm_q[XW-1] && nx;
          exc_d[EXC_NX]  = nx;
        end
      end
      OUT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (Dataout_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      rnd_q   <= RNE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      eop_q   <= 1'b0;
      zsame_q <= 1'b0;
      exp_q   <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      sum_q   <= '0;
      nm_q    <= '0;
      res_q   <= '0;
      exc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      eop_q   <= eop_d;
      zsame_q <= zsame_d;
      exp_q   <= exp_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      sum_q   <= sum_d;
      nm_q    <= nm_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      valid_q <= valid_d;
    end
  end

  assign Data_ready    = (state_q == IDLE);
  assign Dataout       = res_q;
  assign Exc           = exc_q;
  assign Dataout_valid = valid_q;
  assign Debug         = state_q;

endmodule

// File: tb/tb_fp_addsub_engine.sv
// Directed scoreboard bench for fp_addsub_engine in single precision.
module tb_fp_addsub_engine;

  logic        CLK;
  logic        RST;
  logic [31:0] Datain1, Datain2;
  logic        Op;
  logic [1:0]  Rnd_mode;
  logic        Data_valid;
  logic        Data_ready;
  logic [31:0] Dataout;
  logic [3:0]  Exc;
  logic        Dataout_valid;
  logic        Dataout_ready;
  logic [2:0]  Debug;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  exc;
    string       tag;
  } exp_t;

  exp_t sbQ[$];
  int   nAsserts = 0;
  int   nFails   = 0;

  fp_addsub_engine #(.EXP_W(8), .MAN_W(23)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Datain1       (Datain1),
    .Datain2       (Datain2),
    .Op            (Op),
    .Rnd_mode      (Rnd_mode),
    .Data_valid    (Data_valid),
    .Data_ready    (Data_ready),
    .Dataout       (Dataout),
    .Exc           (Exc),
    .Dataout_valid (Dataout_valid),
    .Dataout_ready (Dataout_ready),
    .Debug         (Debug)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Presents one operation at a negedge; the following posedge is the accept edge.
  task automatic driveOp(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [1:0] rnd, input string tag);
    @(negedge CLK);
    Datain1    = a;
    Datain2    = b;
    Op         = op;
    Rnd_mode   = rnd;
    Data_valid = 1'b1;
    checkOutput({tag, "_ready"}, 32'(Data_ready), 32'd1);
    @(posedge CLK);
    #1 Data_valid = 1'b0;
  endtask

  task automatic waitForResult(input int expLat);
    int   cycles;
    exp_t e;
    cycles = 0;
    while (Dataout_valid !== 1'b1 && cycles < 30) begin
      @(posedge CLK);
      #1;
      cycles++;
    end
    e = sbQ.pop_front();
    checkOutput({e.tag, "_valid"}, 32'(Dataout_valid), 32'd1);
    checkOutput({e.tag, "_lat"}, 32'(cycles), 32'(expLat));
    checkOutput({e.tag, "_res"}, Dataout, e.res);
    checkOutput({e.tag, "_exc"}, 32'(Exc), 32'(e.exc));
    if (Dataout_ready) begin
      @(posedge CLK);
      #1;
      checkOutput({e.tag, "_drop"}, 32'(Dataout_valid), 32'd0);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op,
                               input logic [1:0] rnd, input logic [31:0] er,
                               input logic [3:0] ee, input int lat, input string tag);
    exp_t e;
    e.res = er;
    e.exc = ee;
    e.tag = tag;
    sbQ.push_back(e);
    driveOp(a, b, op, rnd, tag);
    waitForResult(lat);
  endtask

  initial begin
    logic seenValid;
    RST           = 1'b1;
    Datain1       = '0;
    Datain2       = '0;
    Op            = 1'b0;
    Rnd_mode      = 2'b00;
    Data_valid    = 1'b0;
    Dataout_ready = 1'b1;

    #12;
    checkOutput("rst_dout",  Dataout, 32'h0);
    checkOutput("rst_exc",   32'(Exc), 32'h0);
    checkOutput("rst_valid", 32'(Dataout_valid), 32'd0);
    checkOutput("rst_debug", 32'(Debug), 32'd0);
    checkOutput("rst_ready", 32'(Data_ready), 32'd1);
    @(negedge CLK);
    RST = 1'b0;

    applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000, 4'b0000, 5, "one_plus_two");
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 2'b00, 32'h00000000, 4'b0000, 5, "sub_zero_rne");
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 2'b11, 32'h80000000, 4'b0000, 5, "sub_zero_rdn");
    applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 32'h7F800000, 4'b0101, 5, "ovf_rne");
    applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, 32'h7F7FFFFF, 4'b0101, 5, "ovf_rtz");
    applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b11, 32'h7F7FFFFF, 4'b0101, 5, "ovf_rdn_pos");
    applyStimulus(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b11, 32'hFF800000, 4'b0101, 5, "ovf_rdn_neg");
    applyStimulus(32'h7F800000, 32'hFF800000, 1'b0, 2'b00, 32'h7FC00000, 4'b1000, 2, "inf_minus_inf");
    applyStimulus(32'h7FC00001, 32'h00000000, 1'b0, 2'b00, 32'h7FC00000, 4'b1000, 2, "nan_in");
    applyStimulus(32'h7F800000, 32'h3F800000, 1'b0, 2'b00, 32'h7F800000, 4'b0000, 2, "inf_plus_one");
    applyStimulus(32'h00000001, 32'h00000001, 1'b0, 2'b00, 32'h00000002, 4'b0000, 5, "subnormals");
    applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 2'b00, 32'h3F800000, 4'b0001, 5, "tie_even");
    applyStimulus(32'h3F800000, 32'h33800001, 1'b0, 2'b00, 32'h3F800001, 4'b0001, 5, "above_half");
    applyStimulus(32'h3F800000, 32'h33800001, 1'b0, 2'b01, 32'h3F800000, 4'b0001, 5, "above_half_rtz");
    applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 2'b10, 32'h3F800001, 4'b0001, 5, "tie_rup");
    applyStimulus(32'h40400000, 32'h3F800000, 1'b1, 2'b00, 32'h40000000, 4'b0000, 5, "three_minus_one");
    applyStimulus(32'h3F800000, 32'hBF000000, 1'b0, 2'b00, 32'h3F000000, 4'b0000, 5, "one_minus_half");
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 2'b00, 32'h80000000, 4'b0000, 5, "neg_zeros");

    // Backpressure: result and flags must hold while new requests are ignored.
    Dataout_ready = 1'b0;
    applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000, 4'b0000, 5, "bp");
    for (int i = 0; i < 10; i++) begin
      Datain1    = $urandom;
      Datain2    = $urandom;
      Data_valid = 1'b1;
      @(posedge CLK);
      #1;
      checkOutput("bp_hold_res",   Dataout, 32'h40400000);
      checkOutput("bp_hold_exc",   32'(Exc), 32'h0);
      checkOutput("bp_hold_valid", 32'(Dataout_valid), 32'd1);
      checkOutput("bp_hold_ready", 32'(Data_ready), 32'd0);
    end
    Data_valid    = 1'b0;
    Dataout_ready = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("bp_release_valid", 32'(Dataout_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(Data_ready), 32'd1);
    seenValid = 1'b0;
    repeat (8) begin
      @(posedge CLK);
      #1;
      seenValid = seenValid | Dataout_valid;
    end
    checkOutput("bp_no_extra", 32'(seenValid), 32'd0);

    // Reset while the operation sits in NORM discards it.
    driveOp(32'h3F800000, 32'h40000000, 1'b0, 2'b00, "rst_mid");
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    checkOutput("rst_mid_in_norm", 32'(Debug), 32'd3);
    RST = 1'b1;
    #2;
    checkOutput("rst_mid_valid", 32'(Dataout_valid), 32'd0);
    checkOutput("rst_mid_debug", 32'(Debug), 32'd0);
    RST = 1'b0;
    seenValid = 1'b0;
    repeat (8) begin
      @(posedge CLK);
      #1;
      seenValid = seenValid | Dataout_valid;
    end
    checkOutput("rst_mid_no_out", 32'(seenValid), 32'd0);
    applyStimulus(32'h40400000, 32'h3F800000, 1'b0, 2'b00, 32'h40800000, 4'b0000, 5, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
